// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit width, constants and digit type
package bcd_pkg;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;
  localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;
  typedef logic [BCD_W-1:0] bcd_digit_t;
endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD digit stage, up/down with terminal-count flag
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step_in,
  input  logic       clr,
  input  logic       down,
  output bcd_digit_t q,
  output logic       tc
);
  bcd_digit_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = BCD_ZERO;
    end else if (step_in) begin
      if (down) begin
        q_d = (q_q == BCD_ZERO) ? BCD_NINE : q_q - 4'd1;
      end else begin
        q_d = (q_q == BCD_NINE) ? BCD_ZERO : q_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= BCD_ZERO;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign tc = down ? (q_q == BCD_ZERO) : (q_q == BCD_NINE);
endmodule

// File: rtl/bcd_count_chain.sv
// rtl/bcd_count_chain.sv - cascaded BCD counter with held copy, carry and sticky ovf
// Optional down-count mode (and the down port) enabled by BCD_UPDOWN_EN.
module bcd_count_chain
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    latch,
`ifdef BCD_UPDOWN_EN
  input  logic                    down,
`endif
  output logic [BCD_W*DIGITS-1:0] count,
  output logic [BCD_W*DIGITS-1:0] held,
  output logic                    carry,
  output logic                    ovf
);
  logic                    dir_down;
  logic [DIGITS-1:0]       step;
  logic [DIGITS-1:0]       tc;
  logic                    wrap;
  logic [BCD_W*DIGITS-1:0] held_q, held_d;
  logic                    ovf_q, ovf_d;

`ifdef BCD_UPDOWN_EN
  assign dir_down = down;
`else
  assign dir_down = 1'b0;
`endif

  // Digit k steps only when every lower digit is at its terminal value.
  genvar k;
  generate
    for (k = 0; k < DIGITS; k++) begin : g_digit
      if (k == 0) begin : g_first
        assign step[k] = en;
      end else begin : g_rest
        assign step[k] = step[k-1] & tc[k-1];
      end
      bcd_digit u_digit (
        .clk     (clk),
        .reset   (reset),
        .step_in (step[k]),
        .clr     (clr),
        .down    (dir_down),
        .q       (count[BCD_W*k +: BCD_W]),
        .tc      (tc[k])
      );
    end
  endgenerate

  assign wrap  = step[DIGITS-1] & tc[DIGITS-1];
  assign carry = wrap & ~clr & ~reset;

  always_comb begin
    held_d = latch ? count : held_q;
    ovf_d  = ovf_q;
    if (clr) begin
      ovf_d = 1'b0;
    end else if (wrap) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      held_q <= held_d;
      ovf_q  <= ovf_d;
    end
  end

  assign held = held_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_bcd_count_chain.sv
// tb/tb_bcd_count_chain.sv - directed checks of bcd_count_chain at DIGITS=4 and DIGITS=2
module tb_bcd_count_chain;
  logic        clk = 1'b0;
  logic        reset4, en4, clr4, latch4, down4;
  logic [15:0] count4, held4;
  logic        carry4, ovf4;
  logic        reset2, en2, clr2, latch2, down2;
  logic [7:0]  count2, held2;
  logic        carry2, ovf2;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  bcd_count_chain #(.DIGITS(4)) u_dut4 (
    .clk   (clk),
    .reset (reset4),
    .en    (en4),
    .clr   (clr4),
    .latch (latch4),
`ifdef BCD_UPDOWN_EN
    .down  (down4),
`endif
    .count (count4),
    .held  (held4),
    .carry (carry4),
    .ovf   (ovf4)
  );

  bcd_count_chain #(.DIGITS(2)) u_dut2 (
    .clk   (clk),
    .reset (reset2),
    .en    (en2),
    .clr   (clr2),
    .latch (latch2),
`ifdef BCD_UPDOWN_EN
    .down  (down2),
`endif
    .count (count2),
    .held  (held2),
    .carry (carry2),
    .ovf   (ovf2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset4 = 1'b1; en4 = 1'b0; clr4 = 1'b0; latch4 = 1'b0; down4 = 1'b0;
    reset2 = 1'b1; en2 = 1'b0; clr2 = 1'b0; latch2 = 1'b0; down2 = 1'b0;
    tick(2);
    chk("rst_count", {16'h0, count4}, 32'h0);
    chk("rst_held",  {16'h0, held4},  32'h0);
    chk("rst_ovf",   {31'h0, ovf4},   32'h0);
    chk("rst_carry", {31'h0, carry4}, 32'h0);

    reset4 = 1'b0;
    en4 = 1'b1;
    tick(12);
    chk("cnt12_count", {16'h0, count4}, 32'h0012);
    chk("cnt12_carry", {31'h0, carry4}, 32'h0);
    chk("cnt12_ovf",   {31'h0, ovf4},   32'h0);

    tick(25);
    chk("cnt37_count", {16'h0, count4}, 32'h0037);
    latch4 = 1'b1; clr4 = 1'b1;
    tick(1);
    latch4 = 1'b0; clr4 = 1'b0;
    chk("gate_held",  {16'h0, held4},  32'h0037);
    chk("gate_count", {16'h0, count4}, 32'h0000);
    chk("gate_ovf",   {31'h0, ovf4},   32'h0);

    tick(50);
    chk("cnt50_count", {16'h0, count4}, 32'h0050);
    #2;
    reset4 = 1'b1;
    #1;
    chk("async_count", {16'h0, count4}, 32'h0);
    chk("async_held",  {16'h0, held4},  32'h0);
    chk("async_ovf",   {31'h0, ovf4},   32'h0);
    tick(2);
    chk("rst_en_count", {16'h0, count4}, 32'h0);
    reset4 = 1'b0;
    tick(1);
    chk("post_rst_count", {16'h0, count4}, 32'h0001);

    tick(122);
    chk("cnt123_count", {16'h0, count4}, 32'h0123);
    en4 = 1'b0;
    tick(2);
    latch4 = 1'b1;
    tick(1);
    latch4 = 1'b0;
    tick(2);
    chk("hold_count", {16'h0, count4}, 32'h0123);
    chk("hold_held",  {16'h0, held4},  32'h0123);

    reset2 = 1'b0;
    en2 = 1'b1;
    tick(98);
    chk("d2_98_count", {24'h0, count2}, 32'h98);
    chk("d2_98_carry", {31'h0, carry2}, 32'h0);
    tick(1);
    chk("d2_99_count", {24'h0, count2}, 32'h99);
    chk("d2_99_carry", {31'h0, carry2}, 32'h1);
    chk("d2_99_ovf",   {31'h0, ovf2},   32'h0);
    tick(1);
    chk("d2_wrap_count", {24'h0, count2}, 32'h00);
    chk("d2_wrap_ovf",   {31'h0, ovf2},   32'h1);
    chk("d2_wrap_carry", {31'h0, carry2}, 32'h0);
    tick(3);
    chk("d2_sticky_count", {24'h0, count2}, 32'h03);
    chk("d2_sticky_ovf",   {31'h0, ovf2},   32'h1);
    tick(96);
    chk("d2_again99", {24'h0, count2}, 32'h99);
    clr2 = 1'b1;
    #1;
    chk("d2_clr_carry", {31'h0, carry2}, 32'h0);
    tick(1);
    clr2 = 1'b0;
    chk("d2_clr_count", {24'h0, count2}, 32'h00);
    chk("d2_clr_ovf",   {31'h0, ovf2},   32'h0);

`ifdef BCD_UPDOWN_EN
    reset4 = 1'b1;
    down4 = 1'b1;
    en4 = 1'b1;
    tick(1);
    reset4 = 1'b0;
    #1;
    chk("dn_carry", {31'h0, carry4}, 32'h1);
    tick(1);
    chk("dn_count", {16'h0, count4}, 32'h9999);
    chk("dn_ovf",   {31'h0, ovf4},   32'h1);
    down4 = 1'b0;
    tick(1);
    chk("dn_up_count", {16'h0, count4}, 32'h0000);
    chk("dn_up_ovf",   {31'h0, ovf4},   32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
